// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - master and bus signals shared by the CPU, OAM DMA and HDMA source bus arbiter
interface mem_bus_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write;
  logic        hdma_req;
  logic [15:0] hdma_src_addr;
  logic        oam_req;
  logic [15:0] oam_src_addr;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_write;
  logic [2:0]  grant;
  logic        hdma_en;
  logic        oam_en;
  logic        cpu_stall;

  modport master (
    output cpu_addr, cpu_wdata, cpu_write, hdma_req, hdma_src_addr, oam_req, oam_src_addr,
    input  bus_addr, bus_wdata, bus_write, grant, hdma_en, oam_en, cpu_stall
  );

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_write, hdma_req, hdma_src_addr, oam_req, oam_src_addr,
    output bus_addr, bus_wdata, bus_write, grant, hdma_en, oam_en, cpu_stall
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - grant FSM sharing the source bus between CPU, OAM DMA and HDMA
module mem_bus_arbiter #(
  parameter int HANDOVER_TICKS = 1
) (
  input logic              clk,
  input logic              reset,
  input logic              cpu_en,
  mem_bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {S_CPU, S_OAM, S_HDMA, S_GAP} state_t;

  localparam logic [1:0] GAP_LOAD = (HANDOVER_TICKS == 0) ? 2'd0 : 2'(HANDOVER_TICKS - 1);

  state_t     state, state_next;
  state_t     next_owner, owner_next;
  state_t     target;
  logic       has_target;
  logic [1:0] gap_cnt, gap_next;
  logic [2:0] grant, grant_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_CPU;
      next_owner <= S_CPU;
      gap_cnt    <= 2'd0;
      grant      <= 3'b001;
    end else begin
      state      <= state_next;
      next_owner <= owner_next;
      gap_cnt    <= gap_next;
      grant      <= grant_next;
    end
  end

  always_comb begin
    state_next = state;
    owner_next = next_owner;
    gap_next   = gap_cnt;
    target     = S_CPU;
    has_target = 1'b0;
    if (cpu_en) begin
      case (state)
        S_CPU: begin
          if (bus.hdma_req) begin
            target = S_HDMA; has_target = 1'b1;
          end else if (bus.oam_req) begin
            target = S_OAM; has_target = 1'b1;
          end
        end
        S_OAM: begin
          if (bus.hdma_req) begin
            target = S_HDMA; has_target = 1'b1;
          end else if (!bus.oam_req) begin
            target = S_CPU; has_target = 1'b1;
          end
        end
        S_HDMA: begin
          if (!bus.hdma_req) begin
            target = bus.oam_req ? S_OAM : S_CPU; has_target = 1'b1;
          end
        end
        S_GAP: begin
          // The owner is picked from live requests, so a request dropped mid-gap is lost.
          if (gap_cnt == 2'd0) begin
            state_next = bus.hdma_req ? S_HDMA : (bus.oam_req ? S_OAM : S_CPU);
          end else begin
            gap_next = gap_cnt - 2'd1;
          end
        end
      endcase
    end
    if (has_target) begin
      if (HANDOVER_TICKS == 0) begin
        state_next = target;
      end else begin
        state_next = S_GAP;
        gap_next   = GAP_LOAD;
        owner_next = target;
      end
    end
  end

  always_comb begin
    grant_next = 3'b000;
    case (state_next)
      S_CPU:  grant_next = 3'b001;
      S_OAM:  grant_next = 3'b010;
      S_HDMA: grant_next = 3'b100;
      S_GAP:  grant_next = 3'b000;
    endcase
  end

  always_comb begin
    bus.bus_addr  = bus.cpu_addr;
    bus.bus_wdata = 8'hff;
    bus.bus_write = 1'b0;
    case (grant)
      3'b001: begin
        bus.bus_addr  = bus.cpu_addr;
        bus.bus_wdata = bus.cpu_wdata;
        bus.bus_write = bus.cpu_write;
      end
      3'b010:  bus.bus_addr = bus.oam_src_addr;
      3'b100:  bus.bus_addr = bus.hdma_src_addr;
      default: bus.bus_addr = bus.cpu_addr;
    endcase
  end

  assign bus.grant     = grant;
  assign bus.hdma_en   = cpu_en & grant[2];
  assign bus.oam_en    = cpu_en & grant[1];
  assign bus.cpu_stall = ~grant[0];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed scoreboard bench for mem_bus_arbiter with handover 0, 1 and 3
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_en;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write;
  logic        hdma_req;
  logic [15:0] hdma_src_addr;
  logic        oam_req;
  logic [15:0] oam_src_addr;

  int errors = 0;
  int checks = 0;
  int hdma_pulses = 0;
  logic [8:0] exp_q[$];
  string      tag_q[$];

  mem_bus_arbiter_if if0 ();
  mem_bus_arbiter_if if1 ();
  mem_bus_arbiter_if if3 ();

  assign if0.cpu_addr = cpu_addr;   assign if1.cpu_addr = cpu_addr;   assign if3.cpu_addr = cpu_addr;
  assign if0.cpu_wdata = cpu_wdata; assign if1.cpu_wdata = cpu_wdata; assign if3.cpu_wdata = cpu_wdata;
  assign if0.cpu_write = cpu_write; assign if1.cpu_write = cpu_write; assign if3.cpu_write = cpu_write;
  assign if0.hdma_req = hdma_req;   assign if1.hdma_req = hdma_req;   assign if3.hdma_req = hdma_req;
  assign if0.oam_req = oam_req;     assign if1.oam_req = oam_req;     assign if3.oam_req = oam_req;
  assign if0.hdma_src_addr = hdma_src_addr; assign if1.hdma_src_addr = hdma_src_addr; assign if3.hdma_src_addr = hdma_src_addr;
  assign if0.oam_src_addr = oam_src_addr;   assign if1.oam_src_addr = oam_src_addr;   assign if3.oam_src_addr = oam_src_addr;

  mem_bus_arbiter #(.HANDOVER_TICKS(0)) dut0 (.clk(clk), .reset(reset), .cpu_en(cpu_en), .bus(if0.slave));
  mem_bus_arbiter #(.HANDOVER_TICKS(1)) dut1 (.clk(clk), .reset(reset), .cpu_en(cpu_en), .bus(if1.slave));
  mem_bus_arbiter #(.HANDOVER_TICKS(3)) dut3 (.clk(clk), .reset(reset), .cpu_en(cpu_en), .bus(if3.slave));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected grants of dut0/dut1/dut3 are queued with the stimulus and compared after the edge.
  task automatic tick(input logic en, input logic [2:0] e0, input logic [2:0] e1,
                      input logic [2:0] e3, input string tag);
    logic [8:0] e;
    string      t;
    cpu_en = en;
    exp_q.push_back({e0, e1, e3});
    tag_q.push_back(tag);
    #1;
    if (if1.hdma_en) hdma_pulses++;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    chk({t, "_g0"}, {13'd0, if0.grant}, {13'd0, e[8:6]});
    chk({t, "_g1"}, {13'd0, if1.grant}, {13'd0, e[5:3]});
    chk({t, "_g3"}, {13'd0, if3.grant}, {13'd0, e[2:0]});
    chk({t, "_onehot"}, {15'd0, $onehot0(if1.grant)}, 16'd1);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; cpu_en = 1'b0;
    cpu_addr = 16'h1234; cpu_wdata = 8'h5a; cpu_write = 1'b1;
    hdma_req = 1'b0; hdma_src_addr = 16'hc010;
    oam_req = 1'b0; oam_src_addr = 16'h8000;
    @(negedge clk); @(negedge clk);
    cpu_en = 1'b1; #1;
    chk("rst_grant", {13'd0, if1.grant}, 16'h0001);
    chk("rst_stall", {15'd0, if1.cpu_stall}, 16'd0);
    chk("rst_hdma_en", {15'd0, if1.hdma_en}, 16'd0);
    chk("rst_oam_en", {15'd0, if1.oam_en}, 16'd0);
    chk("cpu_addr", if1.bus_addr, 16'h1234);
    chk("cpu_wdata", {8'd0, if1.bus_wdata}, 16'h005a);
    chk("cpu_write", {15'd0, if1.bus_write}, 16'd1);
    @(negedge clk);
    reset = 1'b1;

    // HDMA from idle CPU
    hdma_req = 1'b1;
    tick(1, 3'b100, 3'b000, 3'b000, "hdma_t1");
    chk("gap_write", {15'd0, if1.bus_write}, 16'd0);
    chk("gap_stall", {15'd0, if1.cpu_stall}, 16'd1);
    tick(1, 3'b100, 3'b100, 3'b000, "hdma_t2");
    cpu_en = 1'b1; #1;
    chk("hdma_addr", if1.bus_addr, 16'hc010);
    chk("hdma_wdata", {8'd0, if1.bus_wdata}, 16'h00ff);
    chk("hdma_write", {15'd0, if1.bus_write}, 16'd0);
    chk("hdma_en_on", {15'd0, if1.hdma_en}, 16'd1);
    tick(1, 3'b100, 3'b100, 3'b000, "hdma_t3");
    tick(1, 3'b100, 3'b100, 3'b100, "hdma_t4");
    hdma_pulses = 0;
    repeat (20) tick(1, 3'b100, 3'b100, 3'b100, "hdma_hold");
    tick(0, 3'b100, 3'b100, 3'b100, "hdma_noen");
    repeat (8) tick(1, 3'b100, 3'b100, 3'b100, "hdma_hold");
    chk("hdma_pulses", 16'(hdma_pulses), 16'd28);
    hdma_req = 1'b0;
    tick(1, 3'b001, 3'b000, 3'b000, "rel_t1");
    tick(1, 3'b001, 3'b001, 3'b000, "rel_t2");
    tick(1, 3'b001, 3'b001, 3'b000, "rel_t3");
    tick(1, 3'b001, 3'b001, 3'b001, "rel_t4");

    // Asynchronous reset while HDMA owns the bus
    hdma_req = 1'b1;
    tick(1, 3'b100, 3'b000, 3'b000, "pre_rst1");
    tick(1, 3'b100, 3'b100, 3'b000, "pre_rst2");
    cpu_en = 1'b1; #2;
    reset = 1'b0; #1;
    chk("arst_grant", {13'd0, if1.grant}, 16'h0001);
    chk("arst_stall", {15'd0, if1.cpu_stall}, 16'd0);
    chk("arst_hdma_en", {15'd0, if1.hdma_en}, 16'd0);
    hdma_req = 1'b0;
    @(posedge clk); #1;
    chk("arst_hold", {13'd0, if1.grant}, 16'h0001);
    @(negedge clk);
    reset = 1'b1;

    // OAM pre-empted by HDMA, then resumed
    oam_req = 1'b1;
    tick(1, 3'b010, 3'b000, 3'b000, "oam_t1");
    tick(1, 3'b010, 3'b010, 3'b000, "oam_t2");
    cpu_en = 1'b1; #1;
    chk("oam_addr", if1.bus_addr, 16'h8000);
    chk("oam_en_on", {15'd0, if1.oam_en}, 16'd1);
    tick(1, 3'b010, 3'b010, 3'b000, "oam_t3");
    tick(1, 3'b010, 3'b010, 3'b010, "oam_t4");
    hdma_req = 1'b1;
    tick(1, 3'b100, 3'b000, 3'b000, "pre_t1");
    tick(1, 3'b100, 3'b100, 3'b000, "pre_t2");
    cpu_en = 1'b1; #1;
    chk("pre_oam_en", {15'd0, if1.oam_en}, 16'd0);
    chk("pre_hdma_en", {15'd0, if1.hdma_en}, 16'd1);
    tick(1, 3'b100, 3'b100, 3'b000, "pre_t3");
    tick(1, 3'b100, 3'b100, 3'b100, "pre_t4");
    hdma_req = 1'b0;
    tick(1, 3'b010, 3'b000, 3'b000, "res_t1");
    tick(1, 3'b010, 3'b010, 3'b000, "res_t2");
    tick(1, 3'b010, 3'b010, 3'b000, "res_t3");
    tick(1, 3'b010, 3'b010, 3'b010, "res_t4");
    cpu_en = 1'b1; #1;
    chk("res_oam_en", {15'd0, if1.oam_en}, 16'd1);
    oam_req = 1'b0;
    tick(1, 3'b001, 3'b000, 3'b000, "oend_t1");
    tick(1, 3'b001, 3'b001, 3'b000, "oend_t2");
    tick(1, 3'b001, 3'b001, 3'b000, "oend_t3");
    tick(1, 3'b001, 3'b001, 3'b001, "oend_t4");

    // Simultaneous requests: HDMA wins
    hdma_req = 1'b1; oam_req = 1'b1;
    tick(1, 3'b100, 3'b000, 3'b000, "sim_t1");
    tick(1, 3'b100, 3'b100, 3'b000, "sim_t2");
    tick(1, 3'b100, 3'b100, 3'b000, "sim_t3");
    tick(1, 3'b100, 3'b100, 3'b100, "sim_t4");
    cpu_en = 1'b1; #1;
    chk("sim_oam_en", {15'd0, if1.oam_en}, 16'd0);
    hdma_req = 1'b0; oam_req = 1'b0;
    tick(1, 3'b001, 3'b000, 3'b000, "sim_r1");
    tick(1, 3'b001, 3'b001, 3'b000, "sim_r2");
    tick(1, 3'b001, 3'b001, 3'b000, "sim_r3");
    tick(1, 3'b001, 3'b001, 3'b001, "sim_r4");

    // One-tick HDMA pulse is lost in the gap
    hdma_pulses = 0;
    hdma_req = 1'b1;
    tick(1, 3'b100, 3'b000, 3'b000, "pulse_t1");
    hdma_req = 1'b0;
    tick(1, 3'b001, 3'b001, 3'b000, "pulse_t2");
    tick(1, 3'b001, 3'b001, 3'b000, "pulse_t3");
    tick(1, 3'b001, 3'b001, 3'b001, "pulse_t4");
    chk("pulse_hdma_en", 16'(hdma_pulses), 16'd0);

    // cpu_en low mid-gap freezes the FSM
    hdma_req = 1'b1;
    tick(1, 3'b100, 3'b000, 3'b000, "stall_t1");
    repeat (10) tick(0, 3'b100, 3'b000, 3'b000, "stall_noen");
    tick(1, 3'b100, 3'b100, 3'b000, "stall_t2");
    tick(1, 3'b100, 3'b100, 3'b000, "stall_t3");
    tick(1, 3'b100, 3'b100, 3'b100, "stall_t4");
    hdma_req = 1'b0;
    tick(1, 3'b001, 3'b000, 3'b000, "stall_r1");
    tick(1, 3'b001, 3'b001, 3'b000, "stall_r2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares the cartridge/WRAM source bus between three masters: the CPU, the OAM DMA engine and the CGB HDMA engine.
It sequences ownership with a grant state machine and inserts a handover gap between owners. It gates each DMA engine's advance strobe and stalls whichever masters do not own the bus.
It sits between the CPU core, the oam_dma and hdma_controller blocks, and the memory address decoder.

Parameters:
HANDOVER_TICKS, 1, number of cpu_en ticks the bus stays unowned when ownership changes; legal range 0..3.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
cpu_en  input  1  CPU-phase enable; all state advances only when cpu_en=1
cpu_addr  input  16  CPU bus address
cpu_wdata  input  8  CPU write data
cpu_write  input  1  CPU write strobe
hdma_req  input  1  HDMA wants the bus (hdma level from hdma_controller)
hdma_src_addr  input  16  HDMA source read address
oam_req  input  1  OAM DMA wants the bus
oam_src_addr  input  16  OAM DMA source read address
bus_addr  output  16  address driven to the decoder
bus_wdata  output  8  write data to the decoder
bus_write  output  1  write strobe to the decoder
grant  output  3  one-hot owner: bit0 CPU, bit1 OAM, bit2 HDMA; 000 during handover
hdma_en  output  1  cpu_en gated for the HDMA engine
oam_en  output  1  cpu_en gated for the OAM DMA engine
cpu_stall  output  1  CPU must hold its state

Behaviour:
- Reset (reset=0, asynchronous):
  - state=S_CPU, grant=001, gap counter=0.
  - hdma_en=0, oam_en=0, cpu_stall=0.
  - Reset mid-transfer drops DMA ownership immediately.
- States: S_CPU, S_OAM, S_HDMA, S_GAP. A register `next_owner` (2 bits) holds the pending owner.
- Priority: HDMA > OAM > CPU. It is evaluated only on cpu_en ticks while in an owner state.
- S_CPU:
  - On a cpu_en tick with hdma_req=1, target is HDMA; otherwise, with oam_req=1, target is OAM.
  - With a target: if HANDOVER_TICKS=0, go straight to that owner. Else go to S_GAP with gap counter=HANDOVER_TICKS-1 and next_owner=target.
- S_OAM:
  - On a cpu_en tick with hdma_req=1, pre-empt OAM (target HDMA). OAM DMA is paused: oam_en=0, and the engine keeps its pointer.
  - Else on a cpu_en tick with oam_req=0, target is CPU.
  - Same transition rule as S_CPU.
- S_HDMA:
  - Held while hdma_req=1; no pre-emption.
  - On a cpu_en tick with hdma_req=0, target is OAM if oam_req=1, else CPU.
- S_GAP:
  - grant=000, bus_write=0, bus_addr=cpu_addr, cpu_stall=1, hdma_en=0, oam_en=0.
  - Each cpu_en tick: if counter=0, re-evaluate priority from the live requests. Enter the highest requester's state, or S_CPU if none.
  - If counter≠0, decrement.
  - A request dropped during the gap is therefore never granted.
- Datapath:
  - Bus outputs are a combinational mux on the grant register:
    - CPU: cpu_addr/cpu_wdata/cpu_write.
    - OAM and HDMA: the respective src addr, bus_write=0, bus_wdata=8'hff.
  - hdma_en = cpu_en & grant[2]; oam_en = cpu_en & grant[1].
  - cpu_stall = ~grant[0].
- Ownership never changes on a tick with cpu_en=0.
- Output latency: grant changes are visible one clk after the deciding cpu_en tick. A request is granted HANDOVER_TICKS+1 cpu_en ticks after it is first sampled.
- Simultaneous hdma_req and oam_req rise: HDMA wins; OAM waits with oam_en=0 until HDMA releases.
- HDMA release with a pending OAM request goes to OAM, not CPU. The CPU regains the bus only when both DMA requests are low.
- At most one grant bit is set at any time (one-hot or zero invariant).

Test Plan:
- Reset low mid-S_HDMA, then high → grant=001, cpu_stall=0, hdma_en=0 on the first clk after assertion, no cpu_en needed.
- CPU idle, hdma_req rises (HANDOVER_TICKS=1) → tick1 grant=000 (gap), tick2 grant=100. hdma_en pulses on every cpu_en; bus_addr=hdma_src_addr (e.g. 16'hC010). 32 ticks later hdma_req=0 → gap → grant=001.
- oam_req high, hdma_req rises during S_OAM → gap, then grant=100, oam_en=0 throughout HDMA. hdma_req falls → gap, then grant=010 and oam_en resumes.
- hdma_req and oam_req rise on the same tick → grant sequence 001, 000, 100. OAM never granted until hdma_req=0.
- hdma_req pulses high for one tick only → enters S_GAP; req low at gap end → returns to grant=001 with zero hdma_en pulses.
- HANDOVER_TICKS=0 and 3 → grant reaches HDMA after exactly 1 and 4 cpu_en ticks. cpu_en held low for 10 clks mid-gap → no state change.
